hand_round_ctrl: RTL and testbench
==================================

HAND_ROUND_CTRL -- requirements
Module: hand_round_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max WAIT_HANDS cycles before forced resolution (range 1..255).
REQ-002 SHALL have parameter SHOW_CYCLES, default 4, number of cycles the round result is held in SHOW (range 1..15).
REQ-003 SHALL have parameter WIN_SCORE, default 3, score that ends the game (range 1..15).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a round or a new game.
REQ-007 p1_valid / p2_valid  input  1 each  player submits a hand this cycle.
REQ-008 p1_hand / p2_hand  input  2 each  hand code: 0 rock, 1 paper, 2 scissors, 3 illegal.
REQ-009 state  output  4  controller phase: IDLE 0000, WAIT_HANDS 0001, RESOLVE 0010, SHOW 0011, GAME_OVER 0100.
REQ-010 p1_handed / p2_handed  output  1 each  player's hand latched for the current round.
REQ-011 result  output  2  0 draw, 1 P1 wins, 2 P2 wins; valid in SHOW and GAME_OVER.
REQ-012 p1_score / p2_score  output  4 each  rounds won this game.
REQ-013 round_done  output  1  one-cycle pulse on RESOLVE->SHOW.
REQ-014 game_over  output  1  high while state is GAME_OVER.

Function
REQ-015 IDLE: start -> WAIT_HANDS next cycle; timeout counter cleared, handed flags cleared.
REQ-016 WAIT_HANDS: valid with hand 0..2 while the player's handed flag is 0 latches the hand and sets the flag next cycle; hand 3 and repeat submissions are ignored.
REQ-017 Simultaneous p1_valid and p2_valid in one cycle SHALL latch both.
REQ-018 WAIT_HANDS -> RESOLVE the cycle after both flags are 1, or when the counter reaches TIMEOUT_CYCLES-1, whichever first.
REQ-019 Counter increments once per WAIT_HANDS cycle, 8 bits, never wraps (holds at TIMEOUT_CYCLES-1).
REQ-020 RESOLVE (exactly 1 cycle): both handed -> standard rules (paper>rock, scissors>paper, rock>scissors, equal = draw); only one handed -> that player wins; none -> draw.
REQ-021 RESOLVE SHALL increment the winner's score (saturating at 15) and assert round_done; then -> SHOW.
REQ-022 SHOW lasts exactly SHOW_CYCLES cycles, result and handed flags held; exit -> GAME_OVER if either score >= WIN_SCORE, else IDLE with flags cleared.
REQ-023 Input valids outside WAIT_HANDS SHALL be ignored; start outside IDLE and GAME_OVER SHALL be ignored.
REQ-024 GAME_OVER: outputs held; start clears both scores and result and -> IDLE next cycle.

Reset
REQ-025 reset SHALL override all other inputs in the same cycle, including mid-round.
REQ-026 After reset: state IDLE, handed flags 0, latched hands 0, result 0, scores 0, counters 0, round_done 0, game_over 0.

Structure
REQ-027 State encodings, hand codes and result codes SHALL live in shared package hand_game_pkg for use by display and handed-tracking logic.
REQ-028 Win decision SHALL be a combinational sub-module hand_judge (two hands + two handed flags in, 2-bit result out).
REQ-029 Handed flags SHALL be plain registers inside this block.

Verification
REQ-030 Reset, start, P1 rock at cycle 2, P2 scissors at cycle 5 -> RESOLVE next cycle, result 1, p1_score 1, round_done one pulse, SHOW 4 cycles, IDLE.
REQ-031 Both valid same cycle, paper/paper -> result 0, scores unchanged, flags both 1 through SHOW.
REQ-032 TIMEOUT_CYCLES=8, only P2 submits (hand 1) -> RESOLVE after 8 WAIT cycles, result 2, p2_score 1.
REQ-033 P1 sends hand 3 then rock -> only rock latched; repeat P1 valid with paper ignored.
REQ-034 Three P1 wins -> GAME_OVER after third SHOW, game_over 1; start -> scores 0, IDLE.
REQ-035 reset asserted in WAIT_HANDS with P1 handed -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/hand_game_pkg.sv
// rtl/hand_game_pkg.sv - shared encodings for the hand game round controller
// Holds the controller phase encoding, hand codes and round result codes so
// that display and handed-tracking logic elsewhere decode the same values.
package hand_game_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'b0000,
        ST_WAIT_HANDS = 4'b0001,
        ST_RESOLVE    = 4'b0010,
        ST_SHOW       = 4'b0011,
        ST_GAME_OVER  = 4'b0100
    } state_t;

    typedef enum logic [1:0] {
        HAND_ROCK     = 2'd0,
        HAND_PAPER    = 2'd1,
        HAND_SCISSORS = 2'd2,
        HAND_ILLEGAL  = 2'd3
    } hand_t;

    typedef enum logic [1:0] {
        RES_DRAW = 2'd0,
        RES_P1   = 2'd1,
        RES_P2   = 2'd2
    } result_t;

    localparam logic [3:0] SCORE_MAX = 4'd15;

    // True when hand a defeats hand b under the standard rules.
    function automatic logic hand_beats(input logic [1:0] a, input logic [1:0] b);
        return (a == HAND_PAPER    && b == HAND_ROCK)  ||
               (a == HAND_SCISSORS && b == HAND_PAPER) ||
               (a == HAND_ROCK     && b == HAND_SCISSORS);
    endfunction

endpackage

// File: rtl/hand_judge.sv
// rtl/hand_judge.sv - combinational round winner decision
// Ports:
//   p1_hand, p2_hand     latched hand codes
//   p1_handed, p2_handed whether each player actually submitted this round
//   result               RES_DRAW / RES_P1 / RES_P2
module hand_judge
    import hand_game_pkg::*;
(
    input  logic [1:0] p1_hand,
    input  logic [1:0] p2_hand,
    input  logic       p1_handed,
    input  logic       p2_handed,
    output logic [1:0] result
);

    always_comb begin
        result = RES_DRAW;
        if (p1_handed && p2_handed) begin
            if (hand_beats(p1_hand, p2_hand)) begin
                result = RES_P1;
            end else if (hand_beats(p2_hand, p1_hand)) begin
                result = RES_P2;
            end
        end else if (p1_handed) begin
            // A player who never showed a hand forfeits the round.
            result = RES_P1;
        end else if (p2_handed) begin
            result = RES_P2;
        end
    end

endmodule

// File: rtl/hand_round_ctrl.sv
// rtl/hand_round_ctrl.sv - two-player hand game round and score controller
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   start                  begin a round (IDLE) or a new game (GAME_OVER)
//   p1_valid/p2_valid      hand submission strobes, p1_hand/p2_hand codes
//   state                  controller phase (hand_game_pkg::state_t)
//   p1_handed/p2_handed    hand latched for the current round
//   result                 last round result, p1_score/p2_score rounds won
//   round_done             high for the single RESOLVE cycle
//   game_over              high while in GAME_OVER
module hand_round_ctrl
    import hand_game_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned SHOW_CYCLES    = 4,
    parameter int unsigned WIN_SCORE      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       p1_valid,
    input  logic       p2_valid,
    input  logic [1:0] p1_hand,
    input  logic [1:0] p2_hand,
    output logic [3:0] state,
    output logic       p1_handed,
    output logic       p2_handed,
    output logic [1:0] result,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic       round_done,
    output logic       game_over
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] SHOW_LAST    = 4'(SHOW_CYCLES - 1);
    localparam logic [3:0] WIN          = 4'(WIN_SCORE);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] wait_cnt;
    logic [3:0] show_cnt;
    logic [1:0] p1_hand_q;
    logic [1:0] p2_hand_q;
    logic [1:0] judge_result;
    logic       score_hit;

    hand_judge u_judge (
        .p1_hand   (p1_hand_q),
        .p2_hand   (p2_hand_q),
        .p1_handed (p1_handed),
        .p2_handed (p2_handed),
        .result    (judge_result)
    );

    assign score_hit = (p1_score >= WIN) || (p2_score >= WIN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_WAIT_HANDS;
            end
            ST_WAIT_HANDS: begin
                if ((p1_handed && p2_handed) || (wait_cnt == TIMEOUT_LAST)) begin
                    state_d = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                state_d = ST_SHOW;
            end
            ST_SHOW: begin
                // Scores were updated in RESOLVE, so they are final here.
                if (show_cnt == SHOW_LAST) begin
                    state_d = score_hit ? ST_GAME_OVER : ST_IDLE;
                end
            end
            ST_GAME_OVER: begin
                if (start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt  <= '0;
            show_cnt  <= '0;
            p1_hand_q <= '0;
            p2_hand_q <= '0;
            p1_handed <= 1'b0;
            p2_handed <= 1'b0;
            result    <= RES_DRAW;
            p1_score  <= '0;
            p2_score  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        wait_cnt  <= '0;
                        p1_handed <= 1'b0;
                        p2_handed <= 1'b0;
                    end
                end
                ST_WAIT_HANDS: begin
                    if (wait_cnt != TIMEOUT_LAST) wait_cnt <= wait_cnt + 8'd1;
                    if (p1_valid && !p1_handed && p1_hand != HAND_ILLEGAL) begin
                        p1_hand_q <= p1_hand;
                        p1_handed <= 1'b1;
                    end
                    if (p2_valid && !p2_handed && p2_hand != HAND_ILLEGAL) begin
                        p2_hand_q <= p2_hand;
                        p2_handed <= 1'b1;
                    end
                end
                ST_RESOLVE: begin
                    result   <= judge_result;
                    show_cnt <= '0;
                    if (judge_result == RES_P1 && p1_score != SCORE_MAX) p1_score <= p1_score + 4'd1;
                    if (judge_result == RES_P2 && p2_score != SCORE_MAX) p2_score <= p2_score + 4'd1;
                end
                ST_SHOW: begin
                    if (show_cnt != SHOW_LAST) begin
                        show_cnt <= show_cnt + 4'd1;
                    end else if (!score_hit) begin
                        // Flags stay visible in GAME_OVER, cleared only for a new round.
                        p1_handed <= 1'b0;
                        p2_handed <= 1'b0;
                    end
                end
                ST_GAME_OVER: begin
                    if (start) begin
                        p1_score <= '0;
                        p2_score <= '0;
                        result   <= RES_DRAW;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state      = state_q;
    assign round_done = (state_q == ST_RESOLVE);
    assign game_over  = (state_q == ST_GAME_OVER);

endmodule

// File: tb/tb_hand_round_ctrl.sv
// tb/tb_hand_round_ctrl.sv - directed self-checking bench for hand_round_ctrl
module tb_hand_round_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, p1_valid, p2_valid;
    logic [1:0] p1_hand, p2_hand;
    logic [3:0] state;
    logic       p1_handed, p2_handed;
    logic [1:0] result;
    logic [3:0] p1_score, p2_score;
    logic       round_done, game_over;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [3:0] S_IDLE = 4'd0, S_WAIT = 4'd1, S_RES = 4'd2, S_SHOW = 4'd3, S_GO = 4'd4;

    hand_round_ctrl #(.TIMEOUT_CYCLES(8), .SHOW_CYCLES(4), .WIN_SCORE(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .p1_valid   (p1_valid),
        .p2_valid   (p2_valid),
        .p1_hand    (p1_hand),
        .p2_hand    (p2_hand),
        .state      (state),
        .p1_handed  (p1_handed),
        .p2_handed  (p2_handed),
        .result     (result),
        .p1_score   (p1_score),
        .p2_score   (p2_score),
        .round_done (round_done),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start = 0; p1_valid = 0; p2_valid = 0; p1_hand = 0; p2_hand = 0;
    endtask

    // Starts a round, both players submit together, returns in the first SHOW cycle.
    task automatic play_round(input logic [1:0] h1, input logic [1:0] h2);
        start = 1; tick(); start = 0;
        p1_valid = 1; p2_valid = 1; p1_hand = h1; p2_hand = h2;
        tick();
        p1_valid = 0; p2_valid = 0;
        tick();
        chk("pr_resolve", {4'd0, state}, {4'd0, S_RES});
        tick();
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
        chk("rst_state", {4'd0, state}, {4'd0, S_IDLE});
        chk("rst_flags", {6'd0, p1_handed, p2_handed}, 8'd0);
        chk("rst_scores", {p1_score, p2_score}, 8'd0);
        chk("rst_outs", {4'd0, result, round_done, game_over}, 8'd0);

        // P1 rock early, P2 scissors later: P1 wins
        start = 1; tick(); start = 0;
        chk("a_wait", {4'd0, state}, {4'd0, S_WAIT});
        tick();
        p1_valid = 1; p1_hand = 2'd0; tick(); p1_valid = 0;
        chk("a_p1_handed", {7'd0, p1_handed}, 8'd1);
        tick(); tick();
        p2_valid = 1; p2_hand = 2'd2; tick(); p2_valid = 0;
        chk("a_both_wait", {2'd0, p1_handed, p2_handed, state}, {2'd0, 2'b11, S_WAIT});
        tick();
        chk("a_resolve", {3'd0, round_done, state}, {3'd0, 1'b1, S_RES});
        tick();
        chk("a_show", {3'd0, round_done, state}, {3'd0, 1'b0, S_SHOW});
        chk("a_result", {6'd0, result}, 8'd1);
        chk("a_scores", {p1_score, p2_score}, {4'd1, 4'd0});
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("a_show_hold", {4'd0, state}, {4'd0, S_SHOW});
        end
        tick();
        chk("a_idle", {2'd0, p1_handed, p2_handed, state}, {2'd0, 2'b00, S_IDLE});

        // Simultaneous paper/paper: draw
        play_round(2'd1, 2'd1);
        chk("b_result", {6'd0, result}, 8'd0);
        chk("b_scores", {p1_score, p2_score}, {4'd1, 4'd0});
        for (int i = 0; i < 3; i++) begin
            chk("b_flags_show", {2'd0, p1_handed, p2_handed, state}, {2'd0, 2'b11, S_SHOW});
            tick();
        end
        chk("b_flags_show4", {2'd0, p1_handed, p2_handed, state}, {2'd0, 2'b11, S_SHOW});
        tick();
        chk("b_idle", {4'd0, state}, {4'd0, S_IDLE});

        // Illegal hand ignored, repeat submission ignored
        start = 1; tick(); start = 0;
        p1_valid = 1; p1_hand = 2'd3; tick();
        chk("c_illegal", {7'd0, p1_handed}, 8'd0);
        p1_hand = 2'd0; tick();
        chk("c_rock", {7'd0, p1_handed}, 8'd1);
        p1_hand = 2'd1; tick(); p1_valid = 0;
        p2_valid = 1; p2_hand = 2'd2; tick(); p2_valid = 0;
        tick();
        chk("c_resolve", {4'd0, state}, {4'd0, S_RES});
        tick();
        chk("c_result", {6'd0, result}, 8'd1);
        chk("c_scores", {p1_score, p2_score}, {4'd2, 4'd0});
        start = 1; tick(); start = 0;
        chk("c_start_ign", {4'd0, state}, {4'd0, S_SHOW});
        tick(); tick(); tick();
        chk("c_idle", {4'd0, state}, {4'd0, S_IDLE});
        p1_valid = 1; p1_hand = 2'd0; tick(); p1_valid = 0;
        chk("c_valid_idle", {3'd0, p1_handed, state}, {3'd0, 1'b0, S_IDLE});

        // Only P2 submits: timeout after 8 WAIT cycles, P2 wins
        start = 1; tick(); start = 0;
        p2_valid = 1; p2_hand = 2'd1; tick(); p2_valid = 0;
        chk("d_p2_handed", {6'd0, p1_handed, p2_handed}, 8'd1);
        for (int i = 0; i < 6; i++) tick();
        chk("d_wait8", {4'd0, state}, {4'd0, S_WAIT});
        tick();
        chk("d_resolve", {4'd0, state}, {4'd0, S_RES});
        tick();
        chk("d_result", {6'd0, result}, 8'd2);
        chk("d_scores", {p1_score, p2_score}, {4'd2, 4'd1});
        for (int i = 0; i < 4; i++) tick();
        chk("d_idle", {4'd0, state}, {4'd0, S_IDLE});

        // Reset mid-round overrides everything
        start = 1; tick(); start = 0;
        p1_valid = 1; p1_hand = 2'd0; tick(); p1_valid = 0;
        chk("f_p1_handed", {7'd0, p1_handed}, 8'd1);
        reset = 1; start = 1; p2_valid = 1; tick();
        clear_inputs(); reset = 0;
        chk("f_state", {4'd0, state}, {4'd0, S_IDLE});
        chk("f_flags", {6'd0, p1_handed, p2_handed}, 8'd0);
        chk("f_scores", {p1_score, p2_score}, 8'd0);
        chk("f_outs", {4'd0, result, round_done, game_over}, 8'd0);

        // Three P1 wins end the game
        for (int r = 1; r <= 3; r++) begin
            play_round(2'd2, 2'd1);
            chk("e_score", {4'd0, p1_score}, 8'(r));
            chk("e_result", {6'd0, result}, 8'd1);
            for (int i = 0; i < 4; i++) tick();
            if (r < 3) chk("e_idle", {4'd0, state}, {4'd0, S_IDLE});
        end
        chk("e_game_over", {3'd0, game_over, state}, {3'd0, 1'b1, S_GO});
        tick();
        chk("e_go_hold", {p1_score, state}, {4'd3, S_GO});
        start = 1; tick(); start = 0;
        chk("e_new_state", {3'd0, game_over, state}, {3'd0, 1'b0, S_IDLE});
        chk("e_new_scores", {p1_score, p2_score}, 8'd0);
        chk("e_new_result", {6'd0, result}, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
